leve_alu_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares the single LEVE ALU (1-cycle add, RS_D_VALID in / ALU_OUT_VALID out, no stall input) between NREQ requesters.
- Accepts operand pairs over valid/ready, drives the ALU operand port, and tags each op with its requester ID.
- Captures each ALU result into a response FIFO, so responses can be back-pressured even though the ALU cannot stall.
- Issue is credit-gated, so no result is ever lost.

---
 rtl/leve_alu_arb.sv | 136 +++++++++++++
 tb/tb_leve_alu_arb.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leve_alu_arb.sv
// leve_alu_arb: round-robin sharing of the single-cycle LEVE ALU between
// NREQ requesters. Each accepted op is tagged with its requester ID, and its
// result is captured into a small response FIFO. Issue is credit-gated so
// that every result has a FIFO slot when it comes back from the ALU, which
// cannot stall.
module leve_alu_arb #(
    parameter int XLEN  = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic [NREQ-1:0]      REQ_VALID,
    output logic [NREQ-1:0]      REQ_READY,
    input  logic [NREQ*XLEN-1:0] REQ_RS1,
    input  logic [NREQ*XLEN-1:0] REQ_RS2,
    output logic                 RS_D_VALID,
    output logic [XLEN-1:0]      RS1_D,
    output logic [XLEN-1:0]      RS2_D,
    input  logic                 ALU_OUT_VALID,
    input  logic [XLEN-1:0]      ALU_OUT,
    output logic                 RESP_VALID,
    input  logic                 RESP_READY,
    output logic [IDW-1:0]       RESP_ID,
    output logic [XLEN-1:0]      RESP_DATA,
    output logic                 ERR
);

    localparam int AW = $clog2(DEPTH);

    logic [IDW-1:0]  r_rr_ptr;
    logic [AW:0]     r_count;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic            r_inflight_v;
    logic [IDW-1:0]  r_inflight_id;
    logic            r_err;
    logic [IDW-1:0]  r_fifo_id   [DEPTH];
    logic [XLEN-1:0] r_fifo_data [DEPTH];

    logic            w_found;
    logic [IDW-1:0]  w_grant;
    logic [IDW-1:0]  w_next_ptr;
    logic            w_credit_ok;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;

    // Round-robin search: first valid requester at or after r_rr_ptr, with wrap.
    always_comb begin
        int t;
        t       = 0;
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            t = int'(r_rr_ptr) + k;
            if (t >= NREQ) begin
                t = t - NREQ;
            end
            if (!w_found && REQ_VALID[IDW'(t)]) begin
                w_found = 1'b1;
                w_grant = IDW'(t);
            end
        end
    end

    // Credit only counts registered occupancy; a pop this cycle frees a slot
    // from next cycle on, which keeps RESP_READY off the REQ_READY path.
    assign w_credit_ok = (r_count + (AW+1)'(r_inflight_v)) < (AW+1)'(DEPTH);
    assign w_issue     = (|REQ_VALID) && w_credit_ok;
    assign w_next_ptr  = (w_grant == IDW'(NREQ-1)) ? '0 : w_grant + IDW'(1);

    // One-hot accept for the granted requester, only when an op can issue.
    always_comb begin
        REQ_READY = '0;
        if (w_issue) begin
            REQ_READY[w_grant] = 1'b1;
        end
    end

    assign RS_D_VALID = w_issue;
    assign RS1_D      = REQ_RS1[int'(w_grant)*XLEN +: XLEN];
    assign RS2_D      = REQ_RS2[int'(w_grant)*XLEN +: XLEN];

    // A result is only captured when it matches the op issued last cycle.
    assign w_push     = ALU_OUT_VALID & r_inflight_v;
    assign RESP_VALID = (r_count != '0);
    assign w_pop      = RESP_VALID & RESP_READY;
    assign RESP_ID    = r_fifo_id[r_rd_ptr];
    assign RESP_DATA  = r_fifo_data[r_rd_ptr];
    assign ERR        = r_err;

    // Arbitration pointer, in-flight tag, FIFO pointers/occupancy, sticky error.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_rr_ptr      <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_inflight_v  <= 1'b0;
            r_inflight_id <= '0;
            r_err         <= 1'b0;
        end else begin
            r_inflight_v <= w_issue;
            if (w_issue) begin
                r_rr_ptr      <= w_next_ptr;
                r_inflight_id <= w_grant;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            // Result without an op, or an op without a result: both are lost.
            if (ALU_OUT_VALID != r_inflight_v) begin
                r_err <= 1'b1;
            end
        end
    end

    // Response storage; contents are don't-care until written, so no reset.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_id[r_wr_ptr]   <= r_inflight_id;
            r_fifo_data[r_wr_ptr] <= ALU_OUT;
        end
    end

endmodule

// File: tb/tb_leve_alu_arb.sv
// Bench for leve_alu_arb: a 1-cycle adder stands in for the ALU, requesters
// replay per-requester op buffers, and a negedge monitor compares the DUT
// against a queue-based reference of issue order, latency and credit.
module tb_leve_alu_arb;

    localparam int XLEN  = 32;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int DEPTH = 4;
    localparam int BUFN  = 64;

    logic                 CLK = 1'b0;
    logic                 RSTn;
    logic [NREQ-1:0]      REQ_VALID;
    logic [NREQ-1:0]      REQ_READY;
    logic [NREQ*XLEN-1:0] REQ_RS1;
    logic [NREQ*XLEN-1:0] REQ_RS2;
    logic                 RS_D_VALID;
    logic [XLEN-1:0]      RS1_D;
    logic [XLEN-1:0]      RS2_D;
    logic                 ALU_OUT_VALID;
    logic [XLEN-1:0]      ALU_OUT;
    logic                 RESP_VALID;
    logic                 RESP_READY;
    logic [IDW-1:0]       RESP_ID;
    logic [XLEN-1:0]      RESP_DATA;
    logic                 ERR;

    leve_alu_arb #(.XLEN(XLEN), .NREQ(NREQ), .IDW(IDW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_RS1(REQ_RS1), .REQ_RS2(REQ_RS2),
        .RS_D_VALID(RS_D_VALID), .RS1_D(RS1_D), .RS2_D(RS2_D),
        .ALU_OUT_VALID(ALU_OUT_VALID), .ALU_OUT(ALU_OUT),
        .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY),
        .RESP_ID(RESP_ID), .RESP_DATA(RESP_DATA), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Stand-in ALU: registered add, reset shared with the DUT.
    logic            alu_v;
    logic [XLEN-1:0] alu_q;
    logic            inject;
    always @(posedge CLK) begin
        if (!RSTn) begin
            alu_v <= 1'b0;
            alu_q <= '0;
        end else begin
            alu_v <= RS_D_VALID;
            alu_q <= RS1_D + RS2_D;
        end
    end
    assign ALU_OUT_VALID = alu_v | inject;
    assign ALU_OUT       = alu_q;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Per-requester op buffers.
    logic [XLEN-1:0] b1 [NREQ][BUFN];
    logic [XLEN-1:0] b2 [NREQ][BUFN];
    int head [NREQ];
    int tail [NREQ];

    // Reference model state.
    typedef struct {
        int              id;
        logic [XLEN-1:0] data;
        int              avail;
    } exp_t;
    exp_t q[$];
    int   outst  = 0;
    int   m_ptr  = 0;
    bit   m_err  = 0;
    bit   m_prev = 0;
    int   cyc    = 0;

    // Monitor: predict grant/credit/response from the reference and compare.
    always @(negedge CLK) begin
        int g;
        int j;
        bit issue;
        bit exp_rv;
        logic [NREQ-1:0] exp_rdy;
        exp_t e;
        if (!RSTn) begin
            q.delete();
            outst  = 0;
            m_ptr  = 0;
            m_err  = 0;
            m_prev = 0;
        end else begin
            chk("err", ERR, m_err);
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                j = (m_ptr + k) % NREQ;
                if (g < 0 && REQ_VALID[j]) g = j;
            end
            issue   = (g >= 0) && (outst < DEPTH);
            exp_rdy = '0;
            if (issue) exp_rdy[g] = 1'b1;
            chk("req_ready", REQ_READY, exp_rdy);
            chk("rs_d_valid", RS_D_VALID, issue);
            if (issue) begin
                chk("rs1_d", RS1_D, b1[g][head[g] % BUFN]);
                chk("rs2_d", RS2_D, b2[g][head[g] % BUFN]);
            end
            exp_rv = (q.size() > 0) && (q[0].avail <= cyc);
            chk("resp_valid", RESP_VALID, exp_rv);
            if (RESP_VALID && exp_rv) begin
                chk("resp_id", RESP_ID, q[0].id);
                chk("resp_data", RESP_DATA, q[0].data);
                if (RESP_READY) begin
                    void'(q.pop_front());
                    outst--;
                end
            end
            if (issue) begin
                e.id    = g;
                e.data  = b1[g][head[g] % BUFN] + b2[g][head[g] % BUFN];
                e.avail = cyc + 2;
                q.push_back(e);
                outst++;
                m_ptr = (g + 1) % NREQ;
            end
            if (inject && !m_prev) m_err = 1;
            m_prev = issue;
        end
        cyc++;
    end

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            if (head[i] < tail[i]) begin
                REQ_VALID[i] = 1'b1;
                REQ_RS1[i*XLEN +: XLEN] = b1[i][head[i] % BUFN];
                REQ_RS2[i*XLEN +: XLEN] = b2[i][head[i] % BUFN];
            end else begin
                REQ_VALID[i] = 1'b0;
                REQ_RS1[i*XLEN +: XLEN] = '0;
                REQ_RS2[i*XLEN +: XLEN] = '0;
            end
        end
    endtask

    task automatic enq(input int i, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        b1[i][tail[i] % BUFN] = a;
        b2[i][tail[i] % BUFN] = b;
        tail[i]++;
        apply();
    endtask

    function automatic bit all_idle();
        bit r;
        r = (q.size() == 0);
        for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) r = 0;
        return r;
    endfunction

    int rr_mode = 0;  // 0: always ready, 1: random, 2: stalled

    task automatic run(input int n, input bit drain);
        int c;
        logic [NREQ-1:0] hs;
        c = 0;
        while (1) begin
            if (drain && all_idle()) break;
            if (c >= n) begin
                if (drain) begin
                    total++;
                    bad++;
                    $display("FAIL drain_timeout actual=%0d pending required=0", q.size());
                end
                break;
            end
            @(negedge CLK);
            hs = REQ_VALID & REQ_READY;
            @(posedge CLK);
            #1;
            for (int i = 0; i < NREQ; i++) if (hs[i] && head[i] < tail[i]) head[i]++;
            apply();
            case (rr_mode)
                0:       RESP_READY = 1'b1;
                1:       RESP_READY = ($urandom_range(0, 3) != 0);
                default: RESP_READY = 1'b0;
            endcase
            c++;
        end
    endtask

    initial begin
        RSTn = 1'b0;
        inject = 1'b0;
        RESP_READY = 1'b0;
        REQ_VALID = '0;
        REQ_RS1 = '0;
        REQ_RS2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        repeat (3) @(posedge CLK);
        #1 RSTn = 1'b1;
        run(2, 0);

        // single op on requester 2: 5 + 7
        rr_mode = 0;
        enq(2, 32'd5, 32'd7);
        run(20, 1);

        // all requesters continuously valid, full throughput
        for (int n = 0; n < 3; n++)
            for (int i = 0; i < NREQ; i++) enq(i, i, 32'd100);
        run(60, 1);

        // back-pressure: only DEPTH ops accepted, head held
        rr_mode = 2;
        for (int n = 0; n < 2; n++)
            for (int i = 0; i < NREQ; i++) enq(i, $urandom, $urandom);
        run(12, 0);
        rr_mode = 0;
        run(60, 1);

        // push and pop in the same cycle with DEPTH-1 entries queued
        rr_mode = 2;
        for (int n = 0; n < 3; n++) enq(0, $urandom, $urandom);
        run(8, 0);
        enq(1, $urandom, $urandom);
        run(1, 0);
        rr_mode = 0;
        RESP_READY = 1'b1;
        run(40, 1);

        // overflow wrap of the sum plus FIFO pointer wrap
        rr_mode = 1;
        enq(3, 32'hFFFF_FFFF, 32'h0000_0001);
        for (int n = 0; n < 9; n++) enq(3, $urandom, $urandom);
        run(200, 1);

        // randomized traffic
        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < 40; n++) enq($urandom_range(0, NREQ-1), $urandom, $urandom);
            run(1000, 1);
        end

        // spurious ALU result with nothing in flight
        rr_mode = 0;
        run(3, 0);
        inject = 1'b1;
        @(posedge CLK);
        #1 inject = 1'b0;
        run(4, 0);

        // reset with three responses queued
        rr_mode = 2;
        enq(0, $urandom, $urandom);
        enq(1, $urandom, $urandom);
        enq(2, $urandom, $urandom);
        run(8, 0);
        RSTn = 1'b0;
        @(posedge CLK);
        #1 RSTn = 1'b1;
        rr_mode = 0;
        RESP_READY = 1'b1;
        for (int i = 0; i < NREQ; i++) enq(i, $urandom, $urandom);
        run(40, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
